pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//   Generic parametrised pipeline stage register, successor to the fixed per-stage latches.
//   Carries a control bundle (zeroed on bubbles so a bubble acts as a NOP) and a datapath
//   payload, with a valid/ready handshake, stall back-pressure and synchronous flush.
//   Optional 2-entry skid buffer registers InReady, breaking the combinational stall path.
//   Instantiated once per boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
// PARAMETERS
//   CTRL_W  16   width of control bundle (RegWrite, MemRead, ALUControl, ...); cleared on bubble
//   DATA_W  128  width of payload (PC+4, operands, sign-ext, dest reg, ...); never cleared
//   SKID    1    1 = 2-entry skid buffer, registered InReady; 0 = single register
// PORTS
//   Clk        in   1       rising-edge clock
//   Reset      in   1       asynchronous, active-high reset
//   InValid    in   1       upstream stage presents a valid instruction
//   InReady    out  1       this stage accepts InCtrl/InData this cycle
//   InCtrl     in   CTRL_W  upstream control bundle
//   InData     in   DATA_W  upstream payload
//   Flush      in   1       synchronous kill of all held and incoming entries
//   OutValid   out  1       downstream sees a valid entry
//   OutReady   in   1       downstream consumes the entry (0 = stall)
//   OutCtrl    out  CTRL_W  registered control bundle; 0 whenever OutValid=0
//   OutData    out  DATA_W  registered payload
//   Occupancy  out  2       entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
// - Reset (async, immediate): OutValid=0, OutCtrl=0, OutData=0, Occupancy=0, skid empty,
//   InReady=1. Deassertion takes effect at the next Clk edge.
// - Accept = InValid & InReady. Consume = OutValid & OutReady. Latency in->out is 1 cycle.
//   Peak throughput is 1 entry/cycle.
// - SKID=0:
//   - InReady = ~OutValid | OutReady (combinational).
//   - On Accept, the output register loads. On Consume without Accept, OutValid drops to 0.
// - SKID=1: main register (drives outputs) plus one skid register. InReady = ~skid_full,
//   registered, with no combinational path from OutReady. Per edge:
//   - main empty, or consumed with skid empty: Accept loads main.
//   - main consumed with skid full: skid moves to main; an Accept in the same cycle is
//     impossible (InReady=0).
//   - main full and not consumed: Accept loads skid (skid_full=1, so InReady=0 next cycle).
//   - Order is strict FIFO. Entries are never duplicated or reordered.
// - Stall: while OutValid=1 and OutReady=0, OutCtrl and OutData hold bit-stable.
// - Bubble: whenever OutValid=0, OutCtrl=0. OutData keeps its last value (don't-care).
// - Flush (highest priority, synchronous):
//   - Next edge: OutValid=0, OutCtrl=0, skid emptied, Occupancy=0.
//   - An Accept in the flush cycle is discarded. InReady=1 the following cycle.
//   - Flush + OutReady in the same cycle: that cycle's Consume still counts downstream.
// - Occupancy = main_valid + skid_valid, updated at the same edge as the state change.
// - Reset asserted mid-stall or mid-flush: all state is cleared immediately, as at power-up.
// TESTING
// 1. Reset, then InValid=1 for 4 cycles with InCtrl=1..4, OutReady=1
//    -> OutCtrl=1,2,3,4 on cycles 1-4; InReady=1 throughout; Occupancy=1.
// 2. SKID=1: stream InCtrl=A,B,C; OutReady=0 from the cycle A appears
//    -> B captured into skid; InReady=0; Occupancy=2; A held stable.
//    Release OutReady -> A, B, C delivered in order, no loss.
// 3. Flush with Occupancy=2 while InValid=1 (InCtrl=0x5)
//    -> next cycle OutValid=0, OutCtrl=0, Occupancy=0; 0x5 never appears.
// 4. SKID=0, OutValid=1, OutReady=0
//    -> InReady=0 in the same cycle; raise OutReady -> InReady=1 in the same cycle.
// 5. Assert Reset between clock edges during a stall
//    -> OutValid/OutCtrl/Occupancy drop to 0 before the next Clk edge.
// 6. Random InValid/OutReady/Flush for 10k cycles, both SKID values
//    -> scoreboard: in-order delivery, no duplicates, OutCtrl=0 whenever OutValid=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake,
// synchronous flush and an optional 2-entry skid buffer.
module pipe_stage_skid #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int SKID   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
    output logic [1:0]        Occupancy
);

    localparam logic HAS_SKID = (SKID != 0);

    logic              r_main_v;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_v;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_in_ready;
    logic w_accept;
    logic w_consume;
    logic w_main_free;

    // Handshake terms; with a skid buffer InReady comes straight from a flop.
    always_comb begin
        w_in_ready  = HAS_SKID ? ~r_skid_v : (~r_main_v | OutReady);
        w_accept    = InValid & w_in_ready;
        w_consume   = r_main_v & OutReady;
        w_main_free = ~r_main_v | w_consume;
    end

    // Main register: refilled from skid first to keep FIFO order, else from input.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_main_v    <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else if (Flush) begin
            r_main_v    <= 1'b0;
            r_main_ctrl <= '0;
        end else if (w_main_free) begin
            if (r_skid_v) begin
                r_main_v    <= 1'b1;
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end else if (w_accept) begin
                r_main_v    <= 1'b1;
                r_main_ctrl <= InCtrl;
                r_main_data <= InData;
            end else begin
                r_main_v    <= 1'b0;
                r_main_ctrl <= '0;
            end
        end
    end

    // Skid register: catches an accept that arrives while main is stalled.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_skid_v    <= 1'b0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (Flush) begin
            r_skid_v    <= 1'b0;
            r_skid_ctrl <= '0;
        end else if (r_skid_v && w_consume) begin
            r_skid_v    <= 1'b0;
            r_skid_ctrl <= '0;
        end else if (HAS_SKID && w_accept && !w_main_free) begin
            r_skid_v    <= 1'b1;
            r_skid_ctrl <= InCtrl;
            r_skid_data <= InData;
        end
    end

    // Outputs; control is already zero in the main register on a bubble.
    always_comb begin
        InReady   = w_in_ready;
        OutValid  = r_main_v;
        OutCtrl   = r_main_ctrl;
        OutData   = r_main_data;
        Occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: both SKID variants driven by the same
// stimulus and checked against a queue-based model of the stage.
module tb_pipe_stage_skid;

    localparam int CW = 16;
    localparam int DW = 128;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          InValid;
    logic [CW-1:0] InCtrl;
    logic [DW-1:0] InData;
    logic          Flush;
    logic          OutReady;

    logic          ir0, ov0, ir1, ov1;
    logic [CW-1:0] oc0, oc1;
    logic [DW-1:0] od0, od1;
    logic [1:0]    occ0, occ1;

    int total = 0;
    int bad = 0;

    ent_t q0[$];
    ent_t q1[$];

    always #5 Clk = ~Clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u0 (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(ir0),
        .InCtrl(InCtrl), .InData(InData), .Flush(Flush),
        .OutValid(ov0), .OutReady(OutReady), .OutCtrl(oc0),
        .OutData(od0), .Occupancy(occ0)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u1 (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(ir1),
        .InCtrl(InCtrl), .InData(InData), .Flush(Flush),
        .OutValid(ov1), .OutReady(OutReady), .OutCtrl(oc1),
        .OutData(od1), .Occupancy(occ1)
    );

    task automatic chk(input string n, input logic [DW-1:0] a,
                       input logic [DW-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endtask

    // Model: the stage is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
    function automatic logic exp_ready(input int sk, input int sz);
        if (sk != 0) return sz < 2;
        return (sz == 0) || OutReady;
    endfunction

    task automatic compare();
        ent_t h;
        chk("ir0", DW'(ir0), DW'(exp_ready(0, q0.size())));
        chk("ov0", DW'(ov0), DW'(q0.size() > 0));
        chk("occ0", DW'(occ0), DW'(q0.size()));
        if (q0.size() > 0) begin
            h = q0[0];
            chk("oc0", DW'(oc0), DW'(h.c));
            chk("od0", od0, h.d);
        end else chk("oc0_bubble", DW'(oc0), '0);
        chk("ir1", DW'(ir1), DW'(exp_ready(1, q1.size())));
        chk("ov1", DW'(ov1), DW'(q1.size() > 0));
        chk("occ1", DW'(occ1), DW'(q1.size()));
        if (q1.size() > 0) begin
            h = q1[0];
            chk("oc1", DW'(oc1), DW'(h.c));
            chk("od1", od1, h.d);
        end else chk("oc1_bubble", DW'(oc1), '0);
    endtask

    task automatic model_update();
        ent_t e;
        logic a0, a1;
        e.c = InCtrl;
        e.d = InData;
        a0 = InValid && exp_ready(0, q0.size());
        a1 = InValid && exp_ready(1, q1.size());
        if (Reset || Flush) begin
            q0.delete();
            q1.delete();
        end else begin
            if (q0.size() > 0 && OutReady) void'(q0.pop_front());
            if (a0) q0.push_back(e);
            if (q1.size() > 0 && OutReady) void'(q1.pop_front());
            if (a1) q1.push_back(e);
        end
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] c,
                         input logic ordy, input logic fl);
        InValid  = iv;
        InCtrl   = c;
        InData   = {$urandom, $urandom, $urandom, $urandom};
        OutReady = ordy;
        Flush    = fl;
    endtask

    task automatic finish_cycle();
        #1;
        compare();
        model_update();
        @(posedge Clk);
    endtask

    task automatic step(input logic iv, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        @(negedge Clk);
        drive(iv, c, ordy, fl);
        finish_cycle();
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("rst_ov1", DW'(ov1), '0);
        chk("rst_oc1", DW'(oc1), '0);
        chk("rst_od1", od1, '0);
        chk("rst_occ1", DW'(occ1), '0);
        chk("rst_ir1", DW'(ir1), DW'(1));
        chk("rst_ir0", DW'(ir0), DW'(1));
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);

        // Streaming at full rate
        for (int k = 1; k <= 4; k++) step(1'b1, CW'(k), 1'b1, 1'b0);
        @(negedge Clk);
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("t1_oc0", DW'(oc0), DW'(4));
        chk("t1_oc1", DW'(oc1), DW'(4));
        chk("t1_occ1", DW'(occ1), DW'(1));
        finish_cycle();
        step(1'b0, '0, 1'b1, 1'b0);

        // Skid capture and in-order drain
        step(1'b1, CW'('hA), 1'b1, 1'b0);
        step(1'b1, CW'('hB), 1'b0, 1'b0);
        @(negedge Clk);
        drive(1'b1, CW'('hC), 1'b0, 1'b0);
        #1;
        chk("t2_ir1", DW'(ir1), '0);
        chk("t2_occ1", DW'(occ1), DW'(2));
        chk("t2_hold", DW'(oc1), DW'('hA));
        finish_cycle();
        step(1'b1, CW'('hC), 1'b0, 1'b0);
        @(negedge Clk);
        drive(1'b1, CW'('hC), 1'b1, 1'b0);
        #1;
        chk("t2_a", DW'(oc1), DW'('hA));
        finish_cycle();
        @(negedge Clk);
        drive(1'b1, CW'('hC), 1'b1, 1'b0);
        #1;
        chk("t2_b", DW'(oc1), DW'('hB));
        finish_cycle();
        @(negedge Clk);
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        chk("t2_c", DW'(oc1), DW'('hC));
        finish_cycle();

        // Flush with two entries held and an incoming entry
        step(1'b1, CW'('h11), 1'b0, 1'b0);
        step(1'b1, CW'('h12), 1'b0, 1'b0);
        step(1'b1, CW'('h5), 1'b0, 1'b1);
        @(negedge Clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t3_ov1", DW'(ov1), '0);
        chk("t3_oc1", DW'(oc1), '0);
        chk("t3_occ1", DW'(occ1), '0);
        chk("t3_ir1", DW'(ir1), DW'(1));
        finish_cycle();

        // Combinational ready path without skid
        step(1'b1, CW'('h21), 1'b1, 1'b0);
        @(negedge Clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t4_ir0_lo", DW'(ir0), '0);
        OutReady = 1'b1;
        #1;
        chk("t4_ir0_hi", DW'(ir0), DW'(1));
        finish_cycle();

        // Asynchronous reset during a stall
        step(1'b1, CW'('h31), 1'b0, 1'b0);
        step(1'b1, CW'('h32), 1'b0, 1'b0);
        @(negedge Clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        Reset = 1'b1;
        #1;
        chk("t5_ov0", DW'(ov0), '0);
        chk("t5_ov1", DW'(ov1), '0);
        chk("t5_oc1", DW'(oc1), '0);
        chk("t5_occ1", DW'(occ1), '0);
        chk("t5_occ0", DW'(occ0), '0);
        q0.delete();
        q1.delete();
        #1;
        Reset = 1'b0;
        finish_cycle();

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            step($urandom_range(0, 9) < 7,
                 CW'($urandom_range(1, 65535)),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
